// File: rtl/tm_shiftreg_writer.sv
// Serializes a configuration word MSB-first into the TM shift-register chain, pulses load, and captures the readback.
// Latency: start sampled at edge k -> done high in cycle k+1+(DATA_WIDTH+1)*2*HALF_PER; every output is registered.
// Backpressure: start is honoured only in IDLE; a start while busy (including the DONE cycle) is dropped, not queued.
module tm_shiftreg_writer #(
    parameter int DATA_WIDTH = 50,
    parameter int CNT_WIDTH  = 8,
    parameter int HALF_PER   = 2
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  start,
    input  logic                  sr_dout,
    output logic                  sr_clk,
    output logic                  sr_din,
    output logic                  sr_load,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_rb
);

    // ph spans one full sr_clk period: 0..2*HALF_PER-1
    localparam int PH_W = $clog2(2 * HALF_PER);
    localparam logic [PH_W-1:0]      PH_LAST  = PH_W'(2 * HALF_PER - 1);
    localparam logic [PH_W-1:0]      PH_RISE  = PH_W'(HALF_PER - 1);
    localparam logic [PH_W-1:0]      PH_HALF  = PH_W'(HALF_PER);
    localparam logic [CNT_WIDTH-1:0] IDX_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [PH_W-1:0]       r_ph;
    logic [CNT_WIDTH-1:0]  r_idx;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rb;
    logic                  r_sr_clk;
    logic                  r_sr_din;
    logic                  r_sr_load;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_data_rb;

    state_t                w_state_nxt;
    logic [PH_W-1:0]       w_ph_nxt;
    logic [CNT_WIDTH-1:0]  w_idx_nxt;
    logic [DATA_WIDTH-1:0] w_tx_nxt;
    logic [DATA_WIDTH-1:0] w_rb_nxt;
    logic                  w_sr_clk_nxt;
    logic                  w_sr_din_nxt;
    logic                  w_sr_load_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    // Next-state, counters and shifters; outputs are decoded from the next state so they land registered
    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_idx_nxt   = r_idx;
        w_tx_nxt    = r_tx;
        w_rb_nxt    = r_rb;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_tx_nxt    = data_in;
                    w_ph_nxt    = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // sr_clk rises on this edge, and the chain shifts after it, so sr_dout still holds the old bit
                if (r_ph == PH_RISE) begin
                    w_rb_nxt = {r_rb[DATA_WIDTH-2:0], sr_dout};
                end
                if (r_ph == PH_LAST) begin
                    w_ph_nxt = '0;
                    w_tx_nxt = {r_tx[DATA_WIDTH-2:0], 1'b0};
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_idx_nxt = r_idx + CNT_WIDTH'(1);
                    end
                end else begin
                    w_ph_nxt = r_ph + PH_W'(1);
                end
            end
            S_LOAD: begin
                if (r_ph == PH_LAST) begin
                    w_ph_nxt    = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_ph_nxt = r_ph + PH_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_sr_clk_nxt  = (w_state_nxt == S_SHIFT) && (w_ph_nxt >= PH_HALF);
        w_sr_din_nxt  = (w_state_nxt == S_SHIFT) && w_tx_nxt[DATA_WIDTH-1];
        w_sr_load_nxt = (w_state_nxt == S_LOAD);
        w_done_nxt    = (w_state_nxt == S_DONE);
        w_busy_nxt    = (w_state_nxt != S_IDLE);
    end

    // State, datapath and output registers; reset aborts any transfer without load or done
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ph      <= '0;
            r_idx     <= '0;
            r_tx      <= '0;
            r_rb      <= '0;
            r_sr_clk  <= 1'b0;
            r_sr_din  <= 1'b0;
            r_sr_load <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_data_rb <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ph      <= w_ph_nxt;
            r_idx     <= w_idx_nxt;
            r_tx      <= w_tx_nxt;
            r_rb      <= w_rb_nxt;
            r_sr_clk  <= w_sr_clk_nxt;
            r_sr_din  <= w_sr_din_nxt;
            r_sr_load <= w_sr_load_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            if (r_state == S_DONE) begin
                r_data_rb <= r_rb;
            end
        end
    end

    assign sr_clk  = r_sr_clk;
    assign sr_din  = r_sr_din;
    assign sr_load = r_sr_load;
    assign busy    = r_busy;
    assign done    = r_done;
    assign data_rb = r_data_rb;

endmodule

// File: tb/tb_tm_shiftreg_writer.sv
// Directed bench: default instance with a behavioural 50-bit loopback chain, plus an 8-bit HALF_PER=1 instance.
// Outputs are sampled on the falling edge of clk_in; inputs are driven on the falling edge.
// Every wait on the DUT is bounded; an expired wait surfaces as a failed check.
module tb_tm_shiftreg_writer;

    localparam logic [49:0] PRE = 50'h1_5555_AAAA_0F0F;
    localparam logic [49:0] D1  = 50'h2_92BE_AB39_AB39;
    localparam logic [49:0] D2  = 50'h3_0123_4567_89AB;
    localparam logic [49:0] D3  = 50'h0_FFFF_0000_1234;
    localparam logic [49:0] D4  = 50'h1_C3C3_5A5A_9999;
    localparam logic [49:0] D5  = 50'h2_0F0F_F0F0_7E81;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;

    logic [49:0] a_data_in = '0;
    logic        a_start   = 1'b0;
    logic        a_sr_dout;
    logic        a_sr_clk, a_sr_din, a_sr_load, a_busy, a_done;
    logic [49:0] a_data_rb;

    logic [7:0]  b_data_in = '0;
    logic        b_start   = 1'b0;
    logic        b_sr_clk, b_sr_din, b_sr_load, b_busy, b_done;
    logic [7:0]  b_data_rb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int k0     = 0;

    tm_shiftreg_writer u_a (
        .clk_in  (clk_in),
        .rst     (rst),
        .data_in (a_data_in),
        .start   (a_start),
        .sr_dout (a_sr_dout),
        .sr_clk  (a_sr_clk),
        .sr_din  (a_sr_din),
        .sr_load (a_sr_load),
        .busy    (a_busy),
        .done    (a_done),
        .data_rb (a_data_rb)
    );

    tm_shiftreg_writer #(.DATA_WIDTH(8), .CNT_WIDTH(4), .HALF_PER(1)) u_b (
        .clk_in  (clk_in),
        .rst     (rst),
        .data_in (b_data_in),
        .start   (b_start),
        .sr_dout (1'b0),
        .sr_clk  (b_sr_clk),
        .sr_din  (b_sr_din),
        .sr_load (b_sr_load),
        .busy    (b_busy),
        .done    (b_done),
        .data_rb (b_data_rb)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Behavioural TM chain: shifts on sr_clk rising, preloaded whenever rst rises
    logic [49:0] chain;
    always @(posedge a_sr_clk or posedge rst) begin
        if (rst) chain <= PRE;
        else     chain <= {chain[48:0], a_sr_din};
    end
    assign a_sr_dout = chain[49];

    // Event counters for instance A (only ever incremented here)
    int          a_rise = 0, a_load = 0, a_dn = 0, a_bsy = 0;
    logic        a_prev_clk = 1'b0;
    logic [63:0] a_cap = '0;
    always @(negedge clk_in) begin
        a_prev_clk <= a_sr_clk;
        if (a_sr_clk && !a_prev_clk) begin
            a_rise <= a_rise + 1;
            a_cap  <= {a_cap[62:0], a_sr_din};
        end
        if (a_sr_load) a_load <= a_load + 1;
        if (a_done)    a_dn   <= a_dn + 1;
        if (a_busy)    a_bsy  <= a_bsy + 1;
    end

    // Event counters for instance B, including a check that sr_clk toggles every SHIFT cycle
    int          b_rise = 0, b_same = 0;
    logic        b_prev_clk = 1'b0, b_prev_shift = 1'b0;
    logic [63:0] b_cap = '0;
    always @(negedge clk_in) begin
        b_prev_clk   <= b_sr_clk;
        b_prev_shift <= b_busy && !b_sr_load && !b_done;
        if (b_sr_clk && !b_prev_clk) begin
            b_rise <= b_rise + 1;
            b_cap  <= {b_cap[62:0], b_sr_din};
        end
        if (b_busy && !b_sr_load && !b_done && b_prev_shift && (b_sr_clk == b_prev_clk))
            b_same <= b_same + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; k0 is the cycle count right after the sampling edge
    task automatic go(input int sel, input logic [49:0] d, input bit zero_after);
        @(negedge clk_in);
        if (sel == 0) begin a_data_in = d;      a_start = 1'b1; end
        else          begin b_data_in = d[7:0]; b_start = 1'b1; end
        @(negedge clk_in);
        a_start = 1'b0;
        b_start = 1'b0;
        k0 = cyc;
        if (zero_after) a_data_in = '0;
    endtask

    // Wait (bounded) for done; lat is cycles from the start edge, -1 on timeout
    task automatic wait_done(input int sel, output int lat);
        lat = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_in);
            if ((sel == 0 && a_done) || (sel == 1 && b_done)) begin
                lat = cyc - k0;
                break;
            end
        end
    endtask

    int lat;
    int br, bl, bd, bb;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        chk("reset_outs", {59'd0, a_sr_clk, a_sr_din, a_sr_load, a_busy, a_done}, 64'd0);
        chk("reset_rb", {14'd0, a_data_rb}, 64'd0);

        // Transfer 1: serialization, timing, and readback of the preloaded chain
        br = a_rise; bl = a_load; bd = a_dn; bb = a_bsy;
        go(0, D1, 1'b0);
        wait_done(0, lat);
        chk("t1_latency", 64'(lat), 64'd204);
        @(negedge clk_in);
        chk("t1_rb_preload", {14'd0, a_data_rb}, {14'd0, PRE});
        repeat (2) @(negedge clk_in);
        chk("t1_rises", 64'(a_rise - br), 64'd50);
        chk("t1_stream", {14'd0, a_cap[49:0]}, {14'd0, D1});
        chk("t1_load_cycles", 64'(a_load - bl), 64'd4);
        chk("t1_done_pulses", 64'(a_dn - bd), 64'd1);
        chk("t1_busy_cycles", 64'(a_bsy - bb), 64'd205);

        // Transfer 2: data_in cleared right after start; readback returns the first word
        br = a_rise;
        go(0, D2, 1'b1);
        wait_done(0, lat);
        @(negedge clk_in);
        chk("t2_rb_loop", {14'd0, a_data_rb}, {14'd0, D1});
        repeat (2) @(negedge clk_in);
        chk("t2_stream_latched", {14'd0, a_cap[49:0]}, {14'd0, D2});
        chk("t2_rises", 64'(a_rise - br), 64'd50);

        // Transfer 3: starts while busy and in the DONE cycle are ignored
        br = a_rise; bd = a_dn;
        go(0, D3, 1'b0);
        repeat (88) @(negedge clk_in);
        a_start = 1'b1;
        @(negedge clk_in);
        a_start = 1'b0;
        wait_done(0, lat);
        a_start = 1'b1;
        @(negedge clk_in);
        a_start = 1'b0;
        chk("t3_done_start_ignored", {63'd0, a_busy}, 64'd0);
        repeat (20) @(negedge clk_in);
        chk("t3_idle", {63'd0, a_busy}, 64'd0);
        chk("t3_rises", 64'(a_rise - br), 64'd50);
        chk("t3_done_pulses", 64'(a_dn - bd), 64'd1);

        // Transfer 4: reset during bit 20 aborts cleanly, then a fresh transfer works
        br = a_rise; bl = a_load; bd = a_dn;
        go(0, D4, 1'b0);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_in);
            if (a_rise - br >= 21) break;
        end
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        chk("t4_abort_outs", {59'd0, a_sr_clk, a_sr_din, a_sr_load, a_busy, a_done}, 64'd0);
        chk("t4_abort_rb", {14'd0, a_data_rb}, 64'd0);
        repeat (250) @(negedge clk_in);
        chk("t4_no_load", 64'(a_load - bl), 64'd0);
        chk("t4_no_done", 64'(a_dn - bd), 64'd0);
        br = a_rise;
        go(0, D5, 1'b0);
        wait_done(0, lat);
        chk("t4_latency", 64'(lat), 64'd204);
        @(negedge clk_in);
        chk("t4_rb_preload", {14'd0, a_data_rb}, {14'd0, PRE});
        repeat (2) @(negedge clk_in);
        chk("t4_stream", {14'd0, a_cap[49:0]}, {14'd0, D5});
        chk("t4_rises", 64'(a_rise - br), 64'd50);

        // Transfer 5: 8-bit instance, HALF_PER=1
        br = b_rise;
        go(1, 50'hA5, 1'b0);
        wait_done(1, lat);
        chk("t5_latency", 64'(lat), 64'd18);
        repeat (3) @(negedge clk_in);
        chk("t5_rises", 64'(b_rise - br), 64'd8);
        chk("t5_stream", {56'd0, b_cap[7:0]}, 64'hA5);
        chk("t5_toggle", 64'(b_same), 64'd0);
        chk("t5_idle", {63'd0, b_busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
